pu_ex_hilo: RTL

HI/LO architectural register pair with an iterative multiply/divide engine. It sits directly downstream of the EX-stage integer ALU and consumes that ALU's hi/lo/THHI/THLO results (MTHI/MTLO direct writes). It also implements MULT/MULTU/DIV/DIVU as a 33-cycle sequential unit, so builds without IMP_MULT/IMP_DIV still get correct results. Decode/hazard logic stalls on busy; MFHI/MFLO read hi/lo directly.

---
 rtl/pu_ex_hilo_pkg.sv | 28 ++
 rtl/pu_ex_hilo_if.sv | 33 +++
 rtl/pu_ex_div_step.sv | 24 ++
 rtl/pu_ex_hilo.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pu_ex_hilo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pu_ex_hilo_pkg : op codes, state encoding and helpers for HI/LO |
// | Revision       : 1.0                                            |
// +-----------------------------------------------------------------+
package pu_ex_hilo_pkg;

  localparam int PU_MD_ITER = 32;

  typedef logic [1:0] pu_md_op_t;
  localparam pu_md_op_t PU_MD_OP_MULT  = 2'd0;
  localparam pu_md_op_t PU_MD_OP_MULTU = 2'd1;
  localparam pu_md_op_t PU_MD_OP_DIV   = 2'd2;
  localparam pu_md_op_t PU_MD_OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    PU_MD_ST_IDLE = 2'd0,
    PU_MD_ST_MUL  = 2'd1,
    PU_MD_ST_DIV  = 2'd2,
    PU_MD_ST_FIX  = 2'd3
  } pu_md_st_t;

  function automatic logic [31:0] pu_md_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pu_ex_hilo_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pu_ex_hilo_if : request / direct-write / result bundle for HI/LO|
// | Revision      : 1.0                                             |
// +-----------------------------------------------------------------+
interface pu_ex_hilo_if;
  import pu_ex_hilo_pkg::*;

  logic        flush;
  logic        start;
  pu_md_op_t   op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        hi_we;
  logic [31:0] hi_wd;
  logic        lo_we;
  logic [31:0] lo_wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output flush, start, op, in0, in1, hi_we, hi_wd, lo_we, lo_wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  flush, start, op, in0, in1, hi_we, hi_wd, lo_we, lo_wd,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/pu_ex_div_step.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pu_ex_div_step : one restoring-division step (1 quotient bit)   |
// | Revision       : 1.0                                            |
// +-----------------------------------------------------------------+
module pu_ex_div_step (
  input  logic [32:0] i_rem,
  input  logic [31:0] i_divisor,
  input  logic        i_bit,
  output logic [32:0] o_rem,
  output logic        o_q
);

  logic [32:0] w_shift;
  logic [33:0] w_diff;

  assign w_shift = {i_rem[31:0], i_bit};
  assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
  // A set top remainder bit means the shifted value exceeds any 32-bit divisor.
  assign o_q     = i_rem[32] | ~w_diff[33];
  assign o_rem   = o_q ? w_diff[32:0] : w_shift;

endmodule
`default_nettype wire

// File: rtl/pu_ex_hilo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | pu_ex_hilo : HI/LO register pair with 33-cycle mul/div engine   |
// | Revision   : 1.0                                                |
// +-----------------------------------------------------------------+
module pu_ex_hilo
  import pu_ex_hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITER   = PU_MD_ITER
) (
  input  logic         clk,
  input  logic         reset_,
  pu_ex_hilo_if.slave  bus
);

  localparam int c_CNT_W = $clog2(ITER);

  pu_md_st_t            r_state;
  pu_md_st_t            w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_opa;
  logic [DATA_W:0]      r_acc_hi;
  logic [DATA_W-1:0]    r_acc_lo;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_eng_wr;
  logic                 w_last;
  logic                 w_op_div;
  logic                 w_op_signed;
  logic [DATA_W:0]      w_sum;
  logic [DATA_W:0]      w_rem;
  logic                 w_q;
  logic [2*DATA_W-1:0]  w_prod;
  logic [2*DATA_W-1:0]  w_prod_fix;
  logic [DATA_W-1:0]    w_quo_fix;
  logic [DATA_W-1:0]    w_rem_fix;

  assign w_op_div    = (bus.op == PU_MD_OP_DIV) || (bus.op == PU_MD_OP_DIVU);
  assign w_op_signed = (bus.op == PU_MD_OP_MULT) || (bus.op == PU_MD_OP_DIV);
  assign w_last      = (r_cnt == c_CNT_W'(ITER - 1));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_state <= PU_MD_ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_eng_wr = 1'b0;
    unique case (r_state)
      PU_MD_ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          w_accept = 1'b1;
          w_next   = w_op_div ? PU_MD_ST_DIV : PU_MD_ST_MUL;
        end
      end
      PU_MD_ST_MUL, PU_MD_ST_DIV: begin
        if (bus.flush)   w_next = PU_MD_ST_IDLE;
        else if (w_last) w_next = PU_MD_ST_FIX;
      end
      PU_MD_ST_FIX: begin
        w_next   = PU_MD_ST_IDLE;
        w_eng_wr = !bus.flush;
      end
      default: w_next = PU_MD_ST_IDLE;
    endcase
  end

  assign w_sum = {1'b0, r_acc_hi[DATA_W-1:0]} + {1'b0, r_opa};

  pu_ex_div_step u_div_step (
    .i_rem     (r_acc_hi),
    .i_divisor (r_opa),
    .i_bit     (r_acc_lo[DATA_W-1]),
    .o_rem     (w_rem),
    .o_q       (w_q)
  );

  // Multiply keeps the multiplicand in r_opa; divide keeps the divisor there.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt    <= '0;
      r_opa    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      unique case (r_state)
        PU_MD_ST_IDLE: begin
          if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            r_acc_hi <= '0;
            r_opa    <= pu_md_abs(w_op_div ? bus.in1 : bus.in0, w_op_signed);
            r_acc_lo <= pu_md_abs(w_op_div ? bus.in0 : bus.in1, w_op_signed);
            r_neg_q  <= w_op_signed && (bus.in0[DATA_W-1] ^ bus.in1[DATA_W-1]) &&
                        !(w_op_div && (bus.in1 == '0));
            r_neg_r  <= w_op_signed && w_op_div && bus.in0[DATA_W-1];
          end
        end
        PU_MD_ST_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_acc_lo[0]) {r_acc_hi, r_acc_lo} <= {1'b0, w_sum, r_acc_lo[DATA_W-1:1]};
          else             {r_acc_hi, r_acc_lo} <= {2'b00, r_acc_hi[DATA_W-1:0], r_acc_lo[DATA_W-1:1]};
        end
        PU_MD_ST_DIV: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc_hi <= w_rem;
          r_acc_lo <= {r_acc_lo[DATA_W-2:0], w_q};
        end
        default: ;
      endcase
    end
  end

  // Divide-by-zero leaves |in0| as remainder; the dividend-sign fix restores in0.
  assign w_prod     = {r_acc_hi[DATA_W-1:0], r_acc_lo};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? (~r_acc_hi[DATA_W-1:0] + 1'b1) : r_acc_hi[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_eng_wr;
      if (w_eng_wr) begin
        r_hi <= r_is_div ? w_rem_fix : w_prod_fix[2*DATA_W-1:DATA_W];
        r_lo <= r_is_div ? w_quo_fix : w_prod_fix[DATA_W-1:0];
      end else begin
        if (bus.hi_we) r_hi <= bus.hi_wd;
        if (bus.lo_we) r_lo <= bus.lo_wd;
      end
    end
  end

  assign bus.busy = (r_state != PU_MD_ST_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire
